// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, inst} fetched words; clear drops everything.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_inst,
  input  logic              pop,
  output logic              valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] pc_mem;
  logic [DEPTH-1:0][DATA_W-1:0] inst_mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic                         do_pop;

  assign valid     = (count != '0);
  assign do_pop    = pop && valid;
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_mem <= '0;
      for (int i = 0; i < DEPTH; i++) inst_mem[i] <= DATA_W'(NOP);
    end else if (clr) begin
      // Clear beats a same-cycle push: that word belongs to the abandoned stream.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clr && !do_pop && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one-cycle-latency imem reads under FIFO credit, handles redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter int              DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  state_t            state, state_nxt;
  logic              issue, pop, inflight;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    used;

  assign pop       = inst_valid && inst_ready;
  // Slots already committed: buffered words plus the one landing now, less what leaves now.
  assign used      = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign imem_req  = issue;
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:  if (redirect_valid) state_nxt = REDIR;
             else if (en)        state_nxt = RUN;
      RUN:   if (redirect_valid) state_nxt = REDIR;
             else issue = en && (used < (CNT_W+1)'(BUF_DEPTH));
      REDIR: if (redirect_valid) state_nxt = REDIR;
             else if (en)        state_nxt = RUN;
             else                state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      req_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc     <= pc + 1'b1;
          req_pc <= pc;
        end
      end
    end
  end

  fetch_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (redirect_valid),
    .push     (inflight),
    .push_pc  (req_pc),
    .push_inst(imem_rdata),
    .pop      (pop),
    .valid    (inst_valid),
    .head_pc  (inst_pc),
    .head_inst(inst),
    .count    (count)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench: the reference is the ideal instruction stream (sequential PCs restarting at each redirect).
module tb_fetch_sequencer;
  logic        clk = 0;
  logic        rst_n, en, inst_ready, redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req, inst_valid;
  logic [7:0]  imem_addr, inst_pc, pc;
  logic [31:0] imem_rdata, inst;

  logic        imem_req2, inst_valid2;
  logic [7:0]  imem_addr2, inst_pc2, pc2;
  logic [31:0] imem_rdata2, inst2;

  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_next, exp2, prev_pc;
  logic [31:0] prev_inst;
  logic stall_prev;
  int out_cnt;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc));

  fetch_sequencer #(.RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .inst_valid(inst_valid2), .inst_ready(1'b1), .inst(inst2),
    .inst_pc(inst_pc2), .redirect_valid(1'b0), .redirect_pc(8'h00), .pc(pc2));

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  // Memory returns junk when not read, so an untagged capture shows up as bad data.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? word(imem_addr)  : $urandom();
    imem_rdata2 <= imem_req2 ? word(imem_addr2) : $urandom();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 8'd1;
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_next = 8'h00;
    out_cnt  = 0;
    top_up();
  endtask

  // Advance one cycle; a redirect held through that edge restarts the expected stream.
  task automatic step();
    @(posedge clk); #1;
    if (redirect_valid) begin
      exp_q.delete();
      exp_next = redirect_pc;
      out_cnt  = 0;
    end
    top_up();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 20) begin step(); n++; end
    chk(name, inst_valid, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    reset_model();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
      out_cnt    = 0;
      exp2       = 8'hFE;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_inst", inst, prev_inst);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 0, 1);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst", inst, word(e));
        end
      end
      out_cnt = out_cnt + int'(imem_req) - int'(inst_valid && inst_ready);
      if (imem_req) chk("credit_outstanding_le_2", out_cnt <= 2, 1);
      stall_prev = inst_valid && !inst_ready && !redirect_valid;
      prev_pc    = inst_pc;
      prev_inst  = inst;
      if (inst_valid2) begin
        chk("fe_inst_pc", inst_pc2, exp2);
        chk("fe_inst", inst2, word(exp2));
        exp2 = exp2 + 8'd1;
      end
    end
  end

  initial begin
    int first_req, first_vld;
    rst_n = 0; en = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    reset_model();
    #23;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 8'h00);
    chk("rst_pc_fe", pc2, 8'hFE);

    // Free run from reset: request-to-valid latency and in-order stream
    @(posedge clk); #1;
    rst_n = 1; en = 1; inst_ready = 1;
    reset_model();
    first_req = -1; first_vld = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req && first_req < 0) first_req = i;
      if (inst_valid && first_vld < 0) first_vld = i;
    end
    chk("first_req_seen", first_req >= 0, 1);
    chk("req_to_valid_cycles", first_vld - first_req, 2);
    run(20);

    // Decode stall right after the first valid
    do_reset();
    inst_ready = 0;
    wait_valid("stall_first_valid");
    run(5);
    chk("stall_pc0_held", inst_pc, 8'h00);
    chk("stall_no_req", imem_req, 0);
    inst_ready = 1;
    run(10);

    // Redirect with a full FIFO
    inst_ready = 0;
    run(4);
    redirect_valid = 1; redirect_pc = 8'h20;
    step();
    redirect_valid = 0;
    chk("redir_gap_no_req", imem_req, 0);
    chk("redir_fifo_cleared", inst_valid, 0);
    step();
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 8'h20);
    inst_ready = 1;
    run(8);

    // Redirect while streaming (word in flight, pop in the redirect cycle)
    redirect_valid = 1; redirect_pc = 8'h80;
    step();
    redirect_valid = 0;
    chk("redir2_fifo_cleared", inst_valid, 0);
    run(8);

    // Back-to-back redirects: 0x10 must never be delivered
    redirect_valid = 1; redirect_pc = 8'h10;
    step();
    redirect_pc = 8'h30;
    step();
    redirect_valid = 0;
    chk("b2b_gap_no_req", imem_req, 0);
    step();
    chk("b2b_addr", imem_addr, 8'h30);
    run(8);

    // Wrap through 0xFF
    redirect_valid = 1; redirect_pc = 8'hFD;
    step();
    redirect_valid = 0;
    run(10);

    // Asynchronous reset while words are buffered and requested
    begin
      int n = 0;
      while (!(inst_valid && imem_req) && n < 20) begin step(); n++; end
      chk("midrst_precond", inst_valid && imem_req, 1);
    end
    #2 rst_n = 0;
    #1;
    chk("midrst_inst_valid", inst_valid, 0);
    chk("midrst_imem_req", imem_req, 0);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_imem_addr", imem_addr, 8'h00);
    chk("midrst_inst_pc", inst_pc, 8'h00);
    chk("midrst_inst", inst, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    reset_model();
    wait_valid("midrst_restart_valid");
    run(10);

    // Randomized traffic: enable, backpressure and redirects
    for (int i = 0; i < 400; i++) begin
      en             = ($urandom % 8) != 0;
      inst_ready     = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = 8'($urandom);
      step();
    end
    redirect_valid = 0; en = 1; inst_ready = 1;
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
